// File: rtl/multicycle_control.sv
// Multi-cycle CPU sequencing controller.
// A Moore FSM steps each instruction through fetch, decode, execute, memory and write-back.
// A few Mealy qualifiers follow mem_ready (FETCH, MEM_WR) and zero (BRANCH).
// Ports:
//   clk, rst          - system clock and synchronous active-high reset
//   opcode            - IR[15:12], valid from DECODE until retirement
//   zero              - ALU zero flag, used in BRANCH
//   mem_ready         - shared memory completes the current access this cycle
//   PCWrite .. PCsrc  - datapath enables and mux selects
//   state             - current state, for debug
//   instr_done        - one-cycle pulse on instruction retirement
//   illegal           - one-cycle pulse on an unmapped opcode
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [2:0] ALUop,
  output logic [1:0] PCsrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StExecR   = 4'd2;
  localparam logic [3:0] StWbR     = 4'd3;
  localparam logic [3:0] StMemAddr = 4'd4;
  localparam logic [3:0] StMemRd   = 4'd5;
  localparam logic [3:0] StWbLw    = 4'd6;
  localparam logic [3:0] StMemWr   = 4'd7;
  localparam logic [3:0] StBranch  = 4'd8;
  localparam logic [3:0] StJump    = 4'd9;

  localparam logic [3:0] OpAnd = 4'h0;
  localparam logic [3:0] OpOr  = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h6;
  localparam logic [3:0] OpSlt = 4'h7;
  localparam logic [3:0] OpLw  = 4'h8;
  localparam logic [3:0] OpSw  = 4'hA;
  localparam logic [3:0] OpBne = 4'hE;
  localparam logic [3:0] OpJmp = 4'hF;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b011;
  localparam logic [2:0] AluSub = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    ALUop      = 3'b000;
    PCsrc      = 2'b00;
    state      = 4'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    // Reset masks every output so no PC, IR, register or memory write can slip through.
    if (!rst) begin
      state = state_q;
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUsrcB = 2'b01;
          ALUop   = AluAdd;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) state_d = StDecode;
        end
        StDecode: begin
          // Precompute the branch target into ALUOut.
          ALUsrcB = 2'b11;
          ALUop   = AluAdd;
          case (opcode)
            OpAnd, OpOr, OpAdd, OpSub, OpSlt: state_d = StExecR;
            OpLw, OpSw:                       state_d = StMemAddr;
            OpBne:                            state_d = StBranch;
            OpJmp:                            state_d = StJump;
            default: begin
              state_d    = StFetch;
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        StExecR: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b00;
          case (opcode)
            OpAnd:   ALUop = AluAnd;
            OpOr:    ALUop = AluOr;
            OpSub:   ALUop = AluSub;
            OpSlt:   ALUop = AluSlt;
            default: ALUop = AluAdd;
          endcase
          state_d = StWbR;
        end
        StWbR: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemAddr: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
          ALUop   = AluAdd;
          state_d = (opcode == OpLw) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = StWbLw;
        end
        StWbLw: begin
          MemToReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) state_d = StFetch;
        end
        StBranch: begin
          ALUsrcA    = 1'b1;
          ALUsrcB    = 2'b00;
          ALUop      = AluSub;
          PCsrc      = 2'b01;
          PCWrite    = ~zero;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJump: begin
          PCsrc      = 2'b10;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        default: begin
          // Unreachable codes: outputs stay 0, recover to FETCH.
          state_d = StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus per-instruction cycle-count sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, MemToReg, ALUsrcA;
  logic [1:0] ALUsrcB, PCsrc;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic       instr_done, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .PCsrc(PCsrc), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  // {PCWrite,IRWrite,RegWrite,MemRead,MemWrite,IorD,RegDst,MemToReg,ALUsrcA,
  //  ALUsrcB,ALUop,PCsrc,instr_done,illegal}
  logic [17:0] ctl;
  assign ctl = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, MemToReg, ALUsrcA,
                ALUsrcB, ALUop, PCsrc, instr_done, illegal};

  localparam logic [17:0] CZero  = 18'b0;
  localparam logic [17:0] CFetR  = 18'b110100000_01_011_00_00;
  localparam logic [17:0] CFetW  = 18'b000100000_01_011_00_00;
  localparam logic [17:0] CDec   = 18'b000000000_11_011_00_00;
  localparam logic [17:0] CDecIl = 18'b000000000_11_011_00_11;
  localparam logic [17:0] CExAnd = 18'b000000001_00_000_00_00;
  localparam logic [17:0] CExOr  = 18'b000000001_00_001_00_00;
  localparam logic [17:0] CExAdd = 18'b000000001_00_011_00_00;
  localparam logic [17:0] CExSub = 18'b000000001_00_100_00_00;
  localparam logic [17:0] CExSlt = 18'b000000001_00_101_00_00;
  localparam logic [17:0] CWbR   = 18'b001000100_00_000_00_10;
  localparam logic [17:0] CMAddr = 18'b000000001_10_011_00_00;
  localparam logic [17:0] CMRd   = 18'b000101000_00_000_00_00;
  localparam logic [17:0] CWbLw  = 18'b001000010_00_000_00_10;
  localparam logic [17:0] CMWrW  = 18'b000011000_00_000_00_00;
  localparam logic [17:0] CMWrR  = 18'b000011000_00_000_00_10;
  localparam logic [17:0] CBrTk  = 18'b100000001_00_100_01_10;
  localparam logic [17:0] CBrNt  = 18'b000000001_00_100_01_10;
  localparam logic [17:0] CJmp   = 18'b100000000_00_000_10_10;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                         input logic [3:0] st, input logic [17:0] c);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.exp_state = st; v.exp_ctl = c;
    vecs.push_back(v);
  endtask

  // One R-type instruction with mem_ready=1.
  task automatic add_rtype(input logic [3:0] op, input logic [17:0] ex);
    add_vec(0, op, 0, 1, 4'd0, CFetR);
    add_vec(0, op, 0, 1, 4'd1, CDec);
    add_vec(0, op, 0, 1, 4'd2, ex);
    add_vec(0, op, 0, 1, 4'd3, CWbR);
  endtask

  // Run one instruction from FETCH with mem_ready=1 and count cycles and done pulses.
  task automatic run_instr(input logic [3:0] op, input int exp_cyc, input logic exp_ill);
    int cyc = 0;
    int ndone = 0;
    int nill = 0;
    opcode = op; zero = 1'b0; mem_ready = 1'b1; rst = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (instr_done) ndone++;
      if (illegal) nill++;
      @(posedge clk); #1;
      if (state == 4'd0) break;
    end
    checks++;
    if (cyc != exp_cyc) begin
      failures++;
      $display("FAIL cycles op=%h: got %0d expected %0d", op, cyc, exp_cyc);
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL done_count op=%h: got %0d expected 1", op, ndone);
    end
    checks++;
    if (nill != int'(exp_ill)) begin
      failures++;
      $display("FAIL illegal_count op=%h: got %0d expected %0d", op, nill, exp_ill);
    end
  endtask

  initial begin
    // Reset, then ADD.
    add_vec(1, 4'h0, 0, 1, 4'd0, CZero);
    add_vec(1, 4'h0, 0, 1, 4'd0, CZero);
    add_rtype(4'h2, CExAdd);
    add_rtype(4'h0, CExAnd);
    add_rtype(4'h1, CExOr);
    add_rtype(4'h6, CExSub);
    add_rtype(4'h7, CExSlt);
    // LW with a fetch wait and two MEM_RD wait cycles; mem_ready ignored in DECODE.
    add_vec(0, 4'h8, 0, 0, 4'd0, CFetW);
    add_vec(0, 4'h8, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'h8, 0, 0, 4'd1, CDec);
    add_vec(0, 4'h8, 0, 1, 4'd4, CMAddr);
    add_vec(0, 4'h8, 0, 0, 4'd5, CMRd);
    add_vec(0, 4'h8, 0, 0, 4'd5, CMRd);
    add_vec(0, 4'h8, 0, 1, 4'd5, CMRd);
    add_vec(0, 4'h8, 0, 1, 4'd6, CWbLw);
    // BNE taken (zero=0), then not taken (zero=1, mem_ready ignored).
    add_vec(0, 4'hE, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'hE, 0, 1, 4'd1, CDec);
    add_vec(0, 4'hE, 0, 1, 4'd8, CBrTk);
    add_vec(0, 4'hE, 1, 1, 4'd0, CFetR);
    add_vec(0, 4'hE, 1, 1, 4'd1, CDec);
    add_vec(0, 4'hE, 1, 0, 4'd8, CBrNt);
    // Illegal opcode 3, then JMP.
    add_vec(0, 4'h3, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'h3, 0, 1, 4'd1, CDecIl);
    add_vec(0, 4'hF, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'hF, 0, 1, 4'd1, CDec);
    add_vec(0, 4'hF, 0, 1, 4'd9, CJmp);
    // SW completing after one wait.
    add_vec(0, 4'hA, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'hA, 0, 1, 4'd1, CDec);
    add_vec(0, 4'hA, 0, 1, 4'd4, CMAddr);
    add_vec(0, 4'hA, 0, 0, 4'd7, CMWrW);
    add_vec(0, 4'hA, 0, 1, 4'd7, CMWrR);
    // SW abandoned by reset during the MEM_WR wait.
    add_vec(0, 4'hA, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'hA, 0, 1, 4'd1, CDec);
    add_vec(0, 4'hA, 0, 0, 4'd4, CMAddr);
    add_vec(0, 4'hA, 0, 0, 4'd7, CMWrW);
    add_vec(0, 4'hA, 0, 0, 4'd7, CMWrW);
    add_vec(1, 4'hA, 0, 1, 4'd0, CZero);
    add_vec(0, 4'hA, 0, 1, 4'd0, CFetR);
    // Reset held 3 cycles from EXEC_R.
    add_vec(0, 4'h2, 0, 1, 4'd1, CDec);
    add_vec(0, 4'h2, 0, 1, 4'd2, CExAdd);
    add_vec(1, 4'h2, 0, 1, 4'd0, CZero);
    add_vec(1, 4'h2, 0, 0, 4'd0, CZero);
    add_vec(1, 4'h2, 0, 1, 4'd0, CZero);
    add_vec(0, 4'h2, 0, 0, 4'd0, CFetW);
    add_vec(0, 4'h2, 0, 1, 4'd0, CFetR);
    add_vec(0, 4'h2, 0, 1, 4'd1, CDec);
    add_vec(0, 4'h2, 0, 1, 4'd2, CExAdd);
    add_vec(0, 4'h2, 0, 1, 4'd3, CWbR);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      @(negedge clk);
      checks++;
      if (state !== vecs[i].exp_state) begin
        failures++;
        $display("FAIL vec%0d state: got %0d expected %0d", i, state, vecs[i].exp_state);
      end
      checks++;
      if (ctl !== vecs[i].exp_ctl) begin
        failures++;
        $display("FAIL vec%0d ctl: got %b expected %b", i, ctl, vecs[i].exp_ctl);
      end
      @(posedge clk); #1;
    end

    // Table ends in FETCH; cycle counts with mem_ready tied high.
    run_instr(4'h2, 4, 1'b0);
    run_instr(4'h8, 5, 1'b0);
    run_instr(4'hA, 4, 1'b0);
    run_instr(4'hE, 3, 1'b0);
    run_instr(4'hF, 3, 1'b0);
    run_instr(4'h3, 2, 1'b1);
    run_instr(4'hB, 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
